mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting between the EX stage register and the WB stage. It consumes the EX register outputs (ALU result, store data, destination register, control bits) and performs loads and stores against an external variable-latency data memory through a request/acknowledge handshake. While an access is in flight it asserts `freeze` to stall all upstream stages. It then registers the result into the MEM/WB pipeline register.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage_reg.sv | 53 +++++
 rtl/mem_stage.sv | 100 ++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: register widths, memory map base and FSM encoding.
package mem_stage_pkg;

  localparam int LEN_REGISTER    = 32;
  localparam int LEN_REG_ADDRESS = 4;
  localparam int DEFAULT_ADDR_W  = 16;
  localparam logic [LEN_REGISTER-1:0] DEFAULT_MEM_BASE = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Byte address relative to the memory base, converted to a word index.
  function automatic logic [LEN_REGISTER-1:0] word_index(
    input logic [LEN_REGISTER-1:0] byte_addr,
    input logic [LEN_REGISTER-1:0] base
  );
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge port between the MEM stage and the variable-latency data memory.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [LEN_REGISTER-1:0] mem_wdata;
  logic                    mem_ack;
  logic [LEN_REGISTER-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_stage_reg.sv
// MEM/WB pipeline register; a frozen cycle loads a bubble and holds the data fields.
module mem_stage_reg
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_freeze,
  input  logic                       i_take_buf,
  input  logic [LEN_REGISTER-1:0]    i_buf_data,
  input  logic                       i_mem_read,
  input  logic                       i_wb_enable,
  input  logic [LEN_REG_ADDRESS-1:0] i_dest_reg,
  input  logic [LEN_REGISTER-1:0]    i_alu_result,
  output logic                       o_mem_read,
  output logic                       o_wb_enable,
  output logic [LEN_REG_ADDRESS-1:0] o_dest_reg,
  output logic [LEN_REGISTER-1:0]    o_alu_result,
  output logic [LEN_REGISTER-1:0]    o_mem_data
);

  logic                       r_mem_read;
  logic                       r_wb_enable;
  logic [LEN_REG_ADDRESS-1:0] r_dest_reg;
  logic [LEN_REGISTER-1:0]    r_alu_result;
  logic [LEN_REGISTER-1:0]    r_mem_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_read   <= 1'b0;
      r_wb_enable  <= 1'b0;
      r_dest_reg   <= '0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
    end else if (i_freeze) begin
      r_mem_read  <= 1'b0;
      r_wb_enable <= 1'b0;
    end else begin
      r_mem_read   <= i_mem_read;
      r_wb_enable  <= i_wb_enable;
      r_dest_reg   <= i_dest_reg;
      r_alu_result <= i_alu_result;
      // Load data is only meaningful on the cycle that retires a memory access.
      if (i_take_buf) r_mem_data <= i_buf_data;
    end
  end

  assign o_mem_read   = r_mem_read;
  assign o_wb_enable  = r_wb_enable;
  assign o_dest_reg   = r_dest_reg;
  assign o_alu_result = r_alu_result;
  assign o_mem_data   = r_mem_data;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, stalls upstream while an access is open.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [LEN_REGISTER-1:0] MEM_BASE = DEFAULT_MEM_BASE,
  parameter int                      ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic                       wb_enable_in,
  input  logic [LEN_REG_ADDRESS-1:0] dest_reg_in,
  input  logic [LEN_REGISTER-1:0]    alu_result_in,
  input  logic [LEN_REGISTER-1:0]    reg_file_out2_in,
  output logic                       freeze,
  mem_stage_if.master                mem,
  output logic                       mem_read_out,
  output logic                       wb_enable_out,
  output logic [LEN_REG_ADDRESS-1:0] dest_reg_out,
  output logic [LEN_REGISTER-1:0]    alu_result_out,
  output logic [LEN_REGISTER-1:0]    mem_data_out
);

  mem_state_e              r_state;
  logic                    r_req;
  logic                    r_we;
  logic [ADDR_W-1:0]       r_addr;
  logic [LEN_REGISTER-1:0] r_wdata;
  logic [LEN_REGISTER-1:0] r_buf;

  logic                    w_access;
  logic                    w_mem_read;
  logic [LEN_REGISTER-1:0] w_word;
  logic                    w_unused_hi;

  assign w_access    = mem_read_in | mem_write_in;
  assign w_mem_read  = mem_read_in & ~mem_write_in;
  assign w_word      = word_index(alu_result_in, MEM_BASE);
  assign w_unused_hi = ^w_word;

  // Gated by reset so the stall drops the instant reset is asserted, even with a memory op on the inputs.
  assign freeze = rst & (((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_addr  <= w_word[ADDR_W-1:0];
            r_wdata <= reg_file_out2_in;
            r_we    <= mem_write_in;
            r_req   <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem.mem_ack) begin
            if (!r_we) r_buf <= mem.mem_rdata;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  mem_stage_reg u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .i_freeze     (freeze),
    .i_take_buf   (r_state == ST_DONE),
    .i_buf_data   (r_buf),
    .i_mem_read   (w_mem_read),
    .i_wb_enable  (wb_enable_in),
    .i_dest_reg   (dest_reg_in),
    .i_alu_result (alu_result_in),
    .o_mem_read   (mem_read_out),
    .o_wb_enable  (wb_enable_out),
    .o_dest_reg   (dest_reg_out),
    .o_alu_result (alu_result_out),
    .o_mem_data   (mem_data_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a responding memory model plus an in-order scoreboard of MEM/WB results.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    logic        mr;
    logic        wb;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mr = 1'b0, mw = 1'b0, wb = 1'b0;
  logic [3:0]  dest = '0;
  logic [31:0] alu = '0, rf2 = '0;
  logic        freeze;
  logic        mem_read_out, wb_enable_out;
  logic [3:0]  dest_reg_out;
  logic [31:0] alu_result_out, mem_data_out;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [31:0] m_buf = '0;
  logic [31:0] m_out = '0;

  int          g_waits = 0;
  logic [31:0] g_rdata = '0;
  bit          spur_ack = 1'b0;
  int          req_cnt = 0;
  int          low_run = 0;
  int          last_gap = 0;

  mem_stage_if bus ();

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read_in      (mr),
    .mem_write_in     (mw),
    .wb_enable_in     (wb),
    .dest_reg_in      (dest),
    .alu_result_in    (alu),
    .reg_file_out2_in (rf2),
    .freeze           (freeze),
    .mem              (bus.master),
    .mem_read_out     (mem_read_out),
    .wb_enable_out    (wb_enable_out),
    .dest_reg_out     (dest_reg_out),
    .alu_result_out   (alu_result_out),
    .mem_data_out     (mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: acks after g_waits extra cycles of an open request; tracks the low gap between requests.
  always @(negedge clk) begin
    bus.mem_rdata = g_rdata;
    if (spur_ack) begin
      bus.mem_ack = 1'b1;
    end else if (bus.mem_req) begin
      bus.mem_ack = (req_cnt == g_waits);
      req_cnt++;
    end else begin
      bus.mem_ack = 1'b0;
      req_cnt = 0;
    end
    if (bus.mem_req) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic r, input logic w, input logic e,
                       input logic [3:0] d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits);
    exp_t        x;
    exp_t        got;
    int          nfz = 0;
    int          nreq = 0;
    int          leaks = 0;
    bit          done = 1'b0;
    logic [15:0] cap_addr = '0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_wd = '0;
    logic [15:0] exp_addr;
    @(negedge clk);
    mr = r; mw = w; wb = e; dest = d; alu = a; rf2 = wd;
    g_waits = waits; g_rdata = rd;
    x.mr = r & ~w; x.wb = e; x.dest = d; x.alu = a;
    if (r | w) begin
      if (!w) m_buf = rd;
      x.data = m_buf;
    end else begin
      x.data = m_out;
    end
    m_out = x.data;
    sb.push_back(x);
    exp_addr = 16'((a - 32'd1024) >> 2);
    #1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0 && (wb_enable_out !== 1'b0 || mem_read_out !== 1'b0)) leaks++;
      if (freeze) begin
        nfz++;
        if (bus.mem_req) begin
          nreq++;
          cap_addr = bus.mem_addr;
          cap_we   = bus.mem_we;
          cap_wd   = bus.mem_wdata;
        end
        @(negedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    chk({tag, "_completes"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, "_alu_out"},  alu_result_out, got.alu);
      chk({tag, "_dest_out"}, 32'(dest_reg_out), 32'(got.dest));
      chk({tag, "_wb_out"},   32'(wb_enable_out), 32'(got.wb));
      chk({tag, "_mr_out"},   32'(mem_read_out), 32'(got.mr));
      chk({tag, "_data_out"}, mem_data_out, got.data);
    end
    chk({tag, "_freeze_cycles"}, 32'(nfz), (r | w) ? 32'(2 + waits) : 32'd0);
    chk({tag, "_req_cycles"}, 32'(nreq), (r | w) ? 32'(1 + waits) : 32'd0);
    chk({tag, "_bubbles"}, 32'(leaks), 32'd0);
    if (r | w) begin
      chk({tag, "_addr"}, 32'(cap_addr), 32'(exp_addr));
      chk({tag, "_we"}, 32'(cap_we), 32'(w));
      if (w) chk({tag, "_wdata"}, cap_wd, wd);
    end
  endtask

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #2;
    chk("reset_freeze",   32'(freeze), 32'd0);
    chk("reset_req",      32'(bus.mem_req), 32'd0);
    chk("reset_we",       32'(bus.mem_we), 32'd0);
    chk("reset_addr",     32'(bus.mem_addr), 32'd0);
    chk("reset_wdata",    bus.mem_wdata, 32'd0);
    chk("reset_wb_out",   32'(wb_enable_out), 32'd0);
    chk("reset_alu_out",  alu_result_out, 32'd0);
    chk("reset_data_out", mem_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op("nonmem",  1'b0, 1'b0, 1'b1, 4'd3, 32'h5,    32'h0,        32'h0,        0);
    do_op("load",    1'b1, 1'b0, 1'b1, 4'd7, 32'd1032, 32'h0,        32'hDEADBEEF, 0);
    do_op("store",   1'b0, 1'b1, 1'b0, 4'd1, 32'd1024, 32'h12345678, 32'h55555555, 4);
    do_op("load_a",  1'b1, 1'b0, 1'b1, 4'd4, 32'd1036, 32'h0,        32'hA5A50001, 1);
    do_op("load_b",  1'b1, 1'b0, 1'b1, 4'd5, 32'd1100, 32'h0,        32'h0BADF00D, 0);
    chk("b2b_req_gap_ge2", 32'(last_gap >= 2), 32'd1);
    do_op("load_below_base", 1'b1, 1'b0, 1'b1, 4'd6, 32'd1022, 32'h0, 32'h13572468, 2);

    spur_ack = 1'b1;
    do_op("spurious_ack", 1'b0, 1'b0, 1'b1, 4'd9, 32'h77, 32'h0, 32'hFFFFFFFF, 0);
    spur_ack = 1'b0;

    do_op("rw_both", 1'b1, 1'b1, 1'b1, 4'd2, 32'd1028, 32'h0000CAFE, 32'h99999999, 1);

    // Reset in the middle of an access that the memory never acknowledges.
    @(negedge clk);
    mr = 1'b1; mw = 1'b0; wb = 1'b1; dest = 4'd5; alu = 32'd1040; g_waits = 1000;
    #1;
    for (int i = 0; i < 10 && !bus.mem_req; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_busy_req",    32'(bus.mem_req), 32'd1);
    chk("rst_busy_freeze", 32'(freeze), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_req",      32'(bus.mem_req), 32'd0);
    chk("rst_async_freeze",   32'(freeze), 32'd0);
    chk("rst_async_we",       32'(bus.mem_we), 32'd0);
    chk("rst_async_addr",     32'(bus.mem_addr), 32'd0);
    chk("rst_async_wb_out",   32'(wb_enable_out), 32'd0);
    chk("rst_async_mr_out",   32'(mem_read_out), 32'd0);
    chk("rst_async_dest_out", 32'(dest_reg_out), 32'd0);
    chk("rst_async_alu_out",  alu_result_out, 32'd0);
    chk("rst_async_data_out", mem_data_out, 32'd0);
    m_buf = '0;
    m_out = '0;
    @(negedge clk);
    mr = 1'b0; mw = 1'b0; wb = 1'b0; alu = '0;
    spur_ack = 1'b1;
    #2;
    rst = 1'b1;
    do_op("after_rst_late_ack", 1'b0, 1'b0, 1'b1, 4'd2, 32'h42, 32'h0, 32'h31415926, 0);
    chk("after_rst_req_low", 32'(bus.mem_req), 32'd0);
    spur_ack = 1'b0;

    do_op("after_rst_load", 1'b1, 1'b0, 1'b1, 4'd8, 32'd1044, 32'h0, 32'h00C0FFEE, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
